// File: rtl/rvvi_serial_pkg.sv
// Shared types and helpers for the RVVI retirement serializer.
package rvvi_serial_pkg;

    localparam int DROPW    = 16;
    localparam int MAXSLOTS = 64;

    typedef enum logic {
        IDLE,
        WALK
    } walk_state_e;

    typedef struct packed {
        logic [15:0] hart;
        logic [15:0] slot;
    } hs_t;

    function automatic logic [15:0] lowest_set(input logic [MAXSLOTS-1:0] mask);
        logic [15:0] idx;
        idx = '0;
        for (int i = MAXSLOTS - 1; i >= 0; i--) begin
            if (mask[i]) idx = 16'(i);
        end
        return idx;
    endfunction

    function automatic hs_t split_idx(input logic [15:0] i, input int retire);
        hs_t r;
        r.hart = 16'(int'(i) / retire);
        r.slot = 16'(int'(i) % retire);
        return r;
    endfunction

endpackage

// File: rtl/rvvi_group_fifo.sv
// Register-based FIFO of whole retirement groups.
// A pop in the same cycle frees a slot for a push when full.
module rvvi_group_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push_i,
    input  logic                   pop_i,
    input  logic [W-1:0]           wdata_i,
    output logic [W-1:0]           rdata_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_q;
    logic [AW-1:0] rd_q;
    logic [AW:0]   cnt_q;
    logic          do_push;
    logic          do_pop;

    assign full_o  = (cnt_q == (AW+1)'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);
    assign rdata_o = mem_q[rd_q];
    assign count_o = cnt_q;

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q] <= wdata_i;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + AW'(1);
            if (do_pop)  rd_q <= rd_q + AW'(1);
            unique case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + (AW+1)'(1);
                2'b01:   cnt_q <= cnt_q - (AW+1)'(1);
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/rvvi_retire_serializer.sv
// Serializes multi-hart / multi-slot RVVI retirement groups into one
// record per handshake, in flat slot order, with drop accounting.
module rvvi_retire_serializer
    import rvvi_serial_pkg::*;
#(
    parameter int ILEN   = 32,
    parameter int XLEN   = 64,
    parameter int NHART  = 1,
    parameter int RETIRE = 1,
    parameter int DEPTH  = 8,
    parameter int SEQW   = 32
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NHART*RETIRE-1:0]      in_valid,
    input  logic [NHART*RETIRE*ILEN-1:0] in_insn,
    input  logic [NHART*RETIRE*XLEN-1:0] in_pc,
    input  logic [NHART*RETIRE-1:0]      in_trap,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [$clog2(NHART):0]       out_hart,
    output logic [$clog2(RETIRE):0]      out_slot,
    output logic [ILEN-1:0]              out_insn,
    output logic [XLEN-1:0]              out_pc,
    output logic                         out_trap,
    output logic [SEQW-1:0]              out_seq,
    output logic                         overflow,
    output logic [DROPW-1:0]             drop_count,
    output logic [$clog2(DEPTH):0]       occupancy
);

    localparam int S  = NHART * RETIRE;
    localparam int EW = S * (ILEN + XLEN + 2);
    localparam int IW = (S > 1) ? $clog2(S) : 1;
    localparam int NE = 1 << IW;
    localparam int HW = $clog2(NHART) + 1;
    localparam int SW = $clog2(RETIRE) + 1;

    logic [EW-1:0]     head;
    logic              push;
    logic              pop;
    logic              full;
    logic              empty;
    logic [S-1:0]      h_mask;
    logic [S-1:0]      h_trap;
    logic [S*ILEN-1:0] h_insn;
    logic [S*XLEN-1:0] h_pc;

    assign push = |in_valid;

    rvvi_group_fifo #(
        .W     (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (push),
        .pop_i   (pop),
        .wdata_i ({in_valid, in_insn, in_pc, in_trap}),
        .rdata_o (head),
        .full_o  (full),
        .empty_o (empty),
        .count_o (occupancy)
    );

    assign {h_mask, h_insn, h_pc, h_trap} = head;

    // Pad slot arrays to a power of two so idx never selects past the end.
    logic [ILEN-1:0] insn_a [NE];
    logic [XLEN-1:0] pc_a   [NE];
    logic            trap_a [NE];

    for (genvar g = 0; g < NE; g++) begin : g_slot
        if (g < S) begin : g_real
            assign insn_a[g] = h_insn[g*ILEN +: ILEN];
            assign pc_a[g]   = h_pc[g*XLEN +: XLEN];
            assign trap_a[g] = h_trap[g];
        end else begin : g_pad
            assign insn_a[g] = '0;
            assign pc_a[g]   = '0;
            assign trap_a[g] = 1'b0;
        end
    end

    walk_state_e      state_q;
    walk_state_e      state_d;
    logic [S-1:0]     mask_q;
    logic [S-1:0]     mask_d;
    logic [S-1:0]     rem;
    logic [IW-1:0]    idx;
    logic [SEQW-1:0]  seq_q;
    logic [DROPW-1:0] drop_q;
    logic             ovf_q;
    logic             xfer;
    logic             drop;
    hs_t              hs;
    logic             unused_hs;

    assign idx       = IW'(lowest_set(MAXSLOTS'(mask_q)));
    assign rem       = mask_q & ~(S'(1) << idx);
    assign hs        = split_idx(16'(idx), RETIRE);
    assign unused_hs = ^hs;

    assign out_valid = (state_q == WALK);
    assign xfer      = out_valid && out_ready;
    assign drop      = push && full && !pop;

    always_comb begin
        state_d = state_q;
        mask_d  = mask_q;
        pop     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!empty) begin
                    state_d = WALK;
                    mask_d  = h_mask;
                end
            end
            WALK: begin
                if (out_ready) begin
                    mask_d = rem;
                    if (rem == '0) begin
                        pop     = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            mask_q  <= '0;
            seq_q   <= '0;
            drop_q  <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            mask_q  <= mask_d;
            if (xfer) seq_q <= seq_q + SEQW'(1);
            if (drop) begin
                ovf_q <= 1'b1;
                if (drop_q != '1) drop_q <= drop_q + DROPW'(1);
            end
        end
    end

    assign out_hart   = out_valid ? HW'(hs.hart) : '0;
    assign out_slot   = out_valid ? SW'(hs.slot) : '0;
    assign out_insn   = out_valid ? insn_a[idx] : '0;
    assign out_pc     = out_valid ? pc_a[idx] : '0;
    assign out_trap   = out_valid && trap_a[idx];
    assign out_seq    = seq_q;
    assign overflow   = ovf_q;
    assign drop_count = drop_q;

endmodule

// File: tb/tb_rvvi_retire_serializer.sv
// Directed bench for rvvi_retire_serializer with 2 harts x 2 slots,
// a 4-deep group FIFO and a 4-bit sequence counter.
module tb_rvvi_retire_serializer;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [3:0]   in_valid = '0;
    logic [127:0] in_insn = '0;
    logic [255:0] in_pc = '0;
    logic [3:0]   in_trap = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [1:0]   out_hart;
    logic [1:0]   out_slot;
    logic [31:0]  out_insn;
    logic [63:0]  out_pc;
    logic         out_trap;
    logic [3:0]   out_seq;
    logic         overflow;
    logic [15:0]  drop_count;
    logic [2:0]   occupancy;

    int         checks = 0;
    int         errors = 0;
    logic [3:0] exp_seq = '0;

    rvvi_retire_serializer #(
        .ILEN   (32),
        .XLEN   (64),
        .NHART  (2),
        .RETIRE (2),
        .DEPTH  (4),
        .SEQW   (4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_insn    (in_insn),
        .in_pc      (in_pc),
        .in_trap    (in_trap),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_hart   (out_hart),
        .out_slot   (out_slot),
        .out_insn   (out_insn),
        .out_pc     (out_pc),
        .out_trap   (out_trap),
        .out_seq    (out_seq),
        .overflow   (overflow),
        .drop_count (drop_count),
        .occupancy  (occupancy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  valid;
        logic [3:0]  trap;
        logic [31:0] tag;
        int          n;
        logic [15:0] order;
    } vec_t;

    vec_t tbl [6];

    function automatic logic [63:0] pc_of(input logic [31:0] tag, input int i);
        return 64'h8000_0000_0000_0000 + {28'd0, tag, 4'd0} + 64'(i * 4);
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [3:0] v, input logic [3:0] t, input logic [31:0] tag);
        in_valid = v;
        in_trap  = t;
        for (int i = 0; i < 4; i++) begin
            in_insn[i*32 +: 32] = tag + 32'(i);
            in_pc[i*64 +: 64]   = pc_of(tag, i);
        end
    endtask

    task automatic expect_rec(input int idx, input logic [31:0] tag, input logic trp);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!out_valid && n < 20);
        if (!out_valid) begin
            checks++;
            errors++;
            $display("FAIL rec_timeout: got out_valid=0 expected record idx %0d tag %0h", idx, tag);
            return;
        end
        chk("hart", 64'(out_hart), 64'(idx / 2));
        chk("slot", 64'(out_slot), 64'(idx % 2));
        chk("insn", 64'(out_insn), 64'(tag + 32'(idx)));
        chk("pc", out_pc, pc_of(tag, idx));
        chk("trap", 64'(out_trap), 64'(trp));
        chk("seq", 64'(out_seq), 64'(exp_seq));
        if (out_ready) exp_seq++;
    endtask

    initial begin
        tbl[0] = '{4'b1011, 4'b0000, 32'h0000_1000, 3, 16'hF310};
        tbl[1] = '{4'b0001, 4'b0001, 32'h0000_2000, 1, 16'hFFF0};
        tbl[2] = '{4'b1000, 4'b1000, 32'h0000_3000, 1, 16'hFFF3};
        tbl[3] = '{4'b1111, 4'b0100, 32'h0000_4000, 4, 16'h3210};
        tbl[4] = '{4'b0110, 4'b0010, 32'h0000_5000, 2, 16'hFF21};
        tbl[5] = '{4'b0100, 4'b0000, 32'h0000_6000, 1, 16'hFFF2};

        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_occ", 64'(occupancy), 64'd0);
        chk("rst_seq", 64'(out_seq), 64'd0);
        chk("rst_ovf", 64'(overflow), 64'd0);
        chk("rst_drop", 64'(drop_count), 64'd0);
        chk("rst_insn", 64'(out_insn), 64'd0);

        out_ready = 1'b1;
        for (int v = 0; v < 6; v++) begin
            @(negedge clk);
            drive(tbl[v].valid, tbl[v].trap, tbl[v].tag);
            @(negedge clk);
            in_valid = '0;
            for (int k = 0; k < tbl[v].n; k++) begin
                int id;
                id = int'(tbl[v].order[k*4 +: 4]);
                expect_rec(id, tbl[v].tag, tbl[v].trap[id]);
            end
            @(negedge clk);
            chk("tbl_idle", 64'(out_valid), 64'd0);
            chk("tbl_occ", 64'(occupancy), 64'd0);
        end

        // Stall: five cycles held, then exactly one transfer on release.
        out_ready = 1'b0;
        @(negedge clk);
        drive(4'b0101, 4'b0100, 32'h0000_0300);
        @(negedge clk);
        in_valid = '0;
        expect_rec(0, 32'h0000_0300, 1'b0);
        repeat (5) expect_rec(0, 32'h0000_0300, 1'b0);
        out_ready = 1'b1;
        exp_seq++;
        expect_rec(2, 32'h0000_0300, 1'b1);
        @(negedge clk);
        chk("stall_idle", 64'(out_valid), 64'd0);

        // Overflow: six groups into a 4-deep FIFO with the sampler stalled.
        out_ready = 1'b0;
        for (int g = 0; g < 6; g++) begin
            @(negedge clk);
            drive(4'b0001, 4'b0000, 32'h0000_0100 + 32'(g));
        end
        @(negedge clk);
        in_valid = '0;
        chk("ovf_occ", 64'(occupancy), 64'd4);
        chk("ovf_flag", 64'(overflow), 64'd1);
        chk("ovf_drop", 64'(drop_count), 64'd2);
        expect_rec(0, 32'h0000_0100, 1'b0);

        // Last record of the head leaves as a new group arrives on a full FIFO.
        out_ready = 1'b1;
        exp_seq++;
        drive(4'b0010, 4'b0000, 32'h0000_0200);
        @(negedge clk);
        in_valid = '0;
        chk("bypass_drop", 64'(drop_count), 64'd2);
        chk("bypass_occ", 64'(occupancy), 64'd4);
        expect_rec(0, 32'h0000_0101, 1'b0);
        expect_rec(0, 32'h0000_0102, 1'b0);
        expect_rec(0, 32'h0000_0103, 1'b0);
        expect_rec(1, 32'h0000_0200, 1'b0);
        @(negedge clk);
        chk("drain_idle", 64'(out_valid), 64'd0);
        chk("drain_occ", 64'(occupancy), 64'd0);
        chk("sticky_ovf", 64'(overflow), 64'd1);

        // Reset while walking with three groups held.
        out_ready = 1'b0;
        for (int g = 0; g < 3; g++) begin
            @(negedge clk);
            drive(4'b1111, 4'b0000, 32'h0000_0400 + 32'(g * 16));
        end
        @(negedge clk);
        in_valid = '0;
        @(negedge clk);
        chk("pre_rst_occ", 64'(occupancy), 64'd3);
        chk("pre_rst_valid", 64'(out_valid), 64'd1);
        reset = 1'b1;
        #2;
        reset = 1'b0;
        @(negedge clk);
        chk("mid_rst_valid", 64'(out_valid), 64'd0);
        chk("mid_rst_occ", 64'(occupancy), 64'd0);
        chk("mid_rst_seq", 64'(out_seq), 64'd0);
        chk("mid_rst_ovf", 64'(overflow), 64'd0);
        chk("mid_rst_drop", 64'(drop_count), 64'd0);
        exp_seq = '0;

        // Sequence number wraps after 16 records.
        out_ready = 1'b1;
        for (int g = 0; g < 17; g++) begin
            @(negedge clk);
            drive(4'b0001, 4'b0000, 32'h0000_7000 + 32'(g * 16));
            @(negedge clk);
            in_valid = '0;
            expect_rec(0, 32'h0000_7000 + 32'(g * 16), 1'b0);
        end
        @(negedge clk);
        chk("wrap_seq", 64'(out_seq), 64'd1);
        chk("wrap_idle", 64'(out_valid), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
